branch_resolve_queue: RTL

- In-order queue of in-flight branch predictions, downstream of the gshare predictor and fetch stage.
- Fetch pushes each predicted branch (PC, predicted direction, predicted target). Execute resolves branches in program order.
- The block compares each prediction against the actual outcome. It issues the one-cycle update strobe, address and outcome that train the predictor.
- On a mispredict it raises a flush with the redirect PC.

---
 rtl/branch_resolve_queue_if.sv | 39 +++
 rtl/branch_resolve_queue.sv | 105 ++++++++++
 2 files changed

// File: rtl/branch_resolve_queue_if.sv
// Fetch/execute-facing bus of the branch resolve queue.
// The slave modport is the queue side. The master modport is the fetch/execute/predictor side.
interface branch_resolve_queue_if #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32,
  parameter int IDX_W = 8
);
  logic                     push;
  logic [PC_W-1:0]          push_pc;
  logic                     push_pred_taken;
  logic [PC_W-1:0]          push_pred_target;
  logic                     full;
  logic                     empty;
  logic [$clog2(DEPTH):0]   count;
  logic                     resolve_valid;
  logic                     resolve_taken;
  logic [PC_W-1:0]          resolve_target;
  logic                     update;
  logic [IDX_W-1:0]         update_address;
  logic                     branch_taken;
  logic                     flush;
  logic [PC_W-1:0]          redirect_pc;
  logic                     overflow_err;
  logic                     underflow_err;

  modport slave (
    input  push, push_pc, push_pred_taken, push_pred_target,
    input  resolve_valid, resolve_taken, resolve_target,
    output full, empty, count, update, update_address, branch_taken,
    output flush, redirect_pc, overflow_err, underflow_err
  );

  modport master (
    output push, push_pc, push_pred_taken, push_pred_target,
    output resolve_valid, resolve_taken, resolve_target,
    input  full, empty, count, update, update_address, branch_taken,
    input  flush, redirect_pc, overflow_err, underflow_err
  );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted branches. Resolves against execute outcomes, trains the predictor
// and flushes on mispredict. Defining BRQ_STATS_EN adds saturating branch/mispredict counters.
module branch_resolve_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32,
  parameter int IDX_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  branch_resolve_queue_if.slave  bus
`ifdef BRQ_STATS_EN
  ,
  output logic [31:0]            stat_branches,
  output logic [31:0]            stat_mispredicts
`endif
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            pt;
    logic [PC_W-1:0] tgt;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  entry_t             head;
  logic               do_res, mispred, do_push, ovf;

  assign bus.count = count;
  assign bus.full  = (count == CNT_W'(DEPTH));
  assign bus.empty = (count == '0);
  assign head      = mem[rd_ptr];

  always_comb begin
    do_res  = bus.resolve_valid && !bus.empty;
    mispred = do_res && ((head.pt != bus.resolve_taken) ||
              (head.pt && bus.resolve_taken && head.tgt != bus.resolve_target));
    // A same-cycle push behind a mispredict is wrong-path and is dropped.
    do_push = bus.push && !mispred && (!bus.full || do_res);
    ovf     = bus.push && bus.full && !do_res;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= '{pc: bus.push_pc, pt: bus.push_pred_taken, tgt: bus.push_pred_target};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (mispred) begin
      rd_ptr <= rd_ptr + PTR_W'(1);
      wr_ptr <= rd_ptr + PTR_W'(1);
      count  <= '0;
    end else begin
      if (do_res)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      case ({do_push, do_res})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.update         <= 1'b0;
      bus.update_address <= '0;
      bus.branch_taken   <= 1'b0;
      bus.flush          <= 1'b0;
      bus.redirect_pc    <= '0;
      bus.overflow_err   <= 1'b0;
      bus.underflow_err  <= 1'b0;
    end else begin
      bus.update <= do_res;
      bus.flush  <= mispred;
      if (do_res) begin
        bus.update_address <= head.pc[IDX_W-1:0];
        bus.branch_taken   <= bus.resolve_taken;
      end
      if (mispred)
        bus.redirect_pc <= bus.resolve_taken ? bus.resolve_target : head.pc + PC_W'(4);
      if (ovf) bus.overflow_err <= 1'b1;
      if (bus.resolve_valid && bus.empty) bus.underflow_err <= 1'b1;
    end
  end

`ifdef BRQ_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (do_res && stat_branches != 32'hFFFF_FFFF)     stat_branches    <= stat_branches + 32'd1;
      if (mispred && stat_mispredicts != 32'hFFFF_FFFF) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule
